// File: rtl/axi_rr_lock_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_rr_lock_arbiter_if
// Description : Handshake bundle between requesters, the round-robin lock
//               arbiter and the downstream channel.
//                 req_i     - per-requester valid
//                 last_i    - per-requester last-beat flag
//                 ready_i   - downstream ready
//                 valid_o   - downstream valid
//                 gnt_o     - one-hot ready back to the requesters
//                 sel_idx_o - selected requester (mux select)
//                 rr_ptr_o  - current highest-priority index
//                 locked_o  - winner frozen (hold or burst lock)
//               modport master : requester/downstream side
//               modport slave  : arbiter side
// Revision    : 1.0 - initial release
// ============================================================================
interface axi_rr_lock_arbiter_if #(
  parameter int N_REQ = 8,
  parameter int IDX_W = $clog2(N_REQ)
) ();
  logic [N_REQ-1:0] req_i;
  logic [N_REQ-1:0] last_i;
  logic             ready_i;
  logic             valid_o;
  logic [N_REQ-1:0] gnt_o;
  logic [IDX_W-1:0] sel_idx_o;
  logic [IDX_W-1:0] rr_ptr_o;
  logic             locked_o;

  modport master (
    output req_i, last_i, ready_i,
    input  valid_o, gnt_o, sel_idx_o, rr_ptr_o, locked_o
  );

  modport slave (
    input  req_i, last_i, ready_i,
    output valid_o, gnt_o, sel_idx_o, rr_ptr_o, locked_o
  );
endinterface
`default_nettype wire

// File: rtl/axi_rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_rr_lock_arbiter
// Description : N-way round-robin arbiter with valid-hold and burst lock.
//               Free arbitration scans from the priority pointer upward with
//               wrap at N_REQ; an unaccepted offer freezes the winner (HOLD),
//               an accepted non-last beat freezes it until the last beat
//               (LOCK). The pointer moves past the winner only on completion.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - axi_rr_lock_arbiter_if.slave (req/last/ready in,
//                       valid/gnt/sel_idx/rr_ptr/locked out)
// Revision    : 1.0 - initial release
// ============================================================================
module axi_rr_lock_arbiter #(
  parameter int N_REQ        = 8,
  parameter int IDX_W        = $clog2(N_REQ),
  parameter int LOCK_ON_LAST = 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  axi_rr_lock_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_HOLD = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  localparam logic [IDX_W:0]   c_N_EXT = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0] c_LAST  = IDX_W'(N_REQ - 1);
  localparam logic             c_LOL   = (LOCK_ON_LAST != 0);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_rr_ptr_next;
  logic [IDX_W-1:0] r_hold_idx;
  logic [IDX_W-1:0] w_hold_idx_next;

  logic [IDX_W:0]   w_cand;
  logic [IDX_W-1:0] w_arb_idx;
  logic             w_arb_any;
  logic             w_frozen;
  logic [IDX_W-1:0] w_sel;
  logic             w_valid;
  logic             w_hs;
  logic             w_done;
  logic [IDX_W-1:0] w_ptr_adv;

  // Rotating priority scan. The candidate is computed one bit wider so the
  // wrap is a single conditional subtract, which stays correct for N_REQ
  // that is not a power of two.
  always_comb begin
    w_cand    = '0;
    w_arb_idx = r_rr_ptr;
    w_arb_any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_cand >= c_N_EXT) begin
        w_cand = w_cand - c_N_EXT;
      end
      if (!w_arb_any && bus.req_i[w_cand[IDX_W-1:0]]) begin
        w_arb_any = 1'b1;
        w_arb_idx = w_cand[IDX_W-1:0];
      end
    end
  end

  // While frozen only the held requester is visible downstream.
  assign w_frozen  = (r_state != ST_ARB);
  assign w_sel     = w_frozen ? r_hold_idx : w_arb_idx;
  assign w_valid   = w_frozen ? bus.req_i[r_hold_idx] : w_arb_any;
  assign w_hs      = w_valid & bus.ready_i;
  assign w_done    = w_hs & (bus.last_i[w_sel] | ~c_LOL);
  assign w_ptr_adv = (w_sel == c_LAST) ? '0 : w_sel + IDX_W'(1);

  always_comb begin
    w_state_next    = r_state;
    w_rr_ptr_next   = r_rr_ptr;
    w_hold_idx_next = r_hold_idx;
    case (r_state)
      ST_ARB: begin
        if (w_done) begin
          w_rr_ptr_next = w_ptr_adv;
        end else if (w_hs) begin
          w_state_next    = ST_LOCK;
          w_hold_idx_next = w_sel;
        end else if (w_valid) begin
          w_state_next    = ST_HOLD;
          w_hold_idx_next = w_sel;
        end
      end
      ST_HOLD, ST_LOCK: begin
        if (w_done) begin
          w_state_next  = ST_ARB;
          w_rr_ptr_next = w_ptr_adv;
        end else if (w_hs) begin
          w_state_next = ST_LOCK;
        end
      end
      default: begin
        w_state_next = ST_ARB;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_ARB;
      r_rr_ptr   <= '0;
      r_hold_idx <= '0;
    end else begin
      r_state    <= w_state_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_hold_idx <= w_hold_idx_next;
    end
  end

  assign bus.valid_o   = w_valid;
  assign bus.sel_idx_o = w_sel;
  assign bus.rr_ptr_o  = r_rr_ptr;
  assign bus.locked_o  = w_frozen;
  assign bus.gnt_o     = w_hs ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_sel) : '0;

endmodule
`default_nettype wire

// File: tb/tb_axi_rr_lock_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_rr_lock_arbiter
// Description : Self-checking bench. Instance A: N_REQ=5, re-arbitrate every
//               beat. Instance B: N_REQ=8, burst lock on last. Directed
//               scenarios followed by a randomized soak, all cycles compared
//               against a rule-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rr_lock_arbiter;

  logic clk;
  logic rst_n;

  logic [7:0] req_v  [2];
  logic [7:0] last_v [2];
  logic       ready_v[2];

  axi_rr_lock_arbiter_if #(.N_REQ(5)) if_a ();
  axi_rr_lock_arbiter_if #(.N_REQ(8)) if_b ();

  assign if_a.req_i   = req_v[0][4:0];
  assign if_a.last_i  = last_v[0][4:0];
  assign if_a.ready_i = ready_v[0];
  assign if_b.req_i   = req_v[1];
  assign if_b.last_i  = last_v[1];
  assign if_b.ready_i = ready_v[1];

  axi_rr_lock_arbiter #(.N_REQ(5), .LOCK_ON_LAST(0)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  axi_rr_lock_arbiter #(.N_REQ(8), .LOCK_ON_LAST(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A requester is either free-arbitrated or "frozen" on a held index;
  // HOLD and LOCK behave identically from the outside.
  bit m_frozen[2];
  int m_ptr   [2];
  int m_hold  [2];

  function automatic int n_of(input int d);
    return (d == 0) ? 5 : 8;
  endfunction

  function automatic bit lol_of(input int d);
    return (d == 0) ? 1'b0 : 1'b1;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_frozen[d] = 1'b0;
      m_ptr[d]    = 0;
      m_hold[d]   = 0;
    end
  endfunction

  function automatic void model_out(input int d, output int sel, output bit valid,
                                    output int unsigned gnt);
    int n;
    int idx;
    n = n_of(d);
    if (m_frozen[d]) begin
      sel   = m_hold[d];
      valid = req_v[d][sel];
    end else begin
      sel   = m_ptr[d];
      valid = 1'b0;
      for (int k = 0; k < n; k++) begin
        idx = (m_ptr[d] + k) % n;
        if (!valid && req_v[d][idx]) begin
          sel   = idx;
          valid = 1'b1;
        end
      end
    end
    gnt = (valid && ready_v[d]) ? (32'd1 << sel) : 32'd0;
  endfunction

  function automatic void model_step(input int d);
    int          sel;
    bit          valid;
    int unsigned gnt;
    bit          done;
    model_out(d, sel, valid, gnt);
    done = valid && ready_v[d] && (last_v[d][sel] || !lol_of(d));
    if (done) begin
      m_frozen[d] = 1'b0;
      m_ptr[d]    = (sel + 1) % n_of(d);
    end else if (valid) begin
      m_frozen[d] = 1'b1;
      m_hold[d]   = sel;
    end
  endfunction

  // ---------------- per-cycle comparison ----------------
  int unsigned cap_gnt   [2];
  int unsigned cap_sel   [2];
  int unsigned cap_ptr   [2];
  int unsigned cap_valid [2];
  int unsigned cap_locked[2];

  task automatic sample();
    cap_gnt[0]    = {27'd0, if_a.gnt_o};
    cap_sel[0]    = {29'd0, if_a.sel_idx_o};
    cap_ptr[0]    = {29'd0, if_a.rr_ptr_o};
    cap_valid[0]  = {31'd0, if_a.valid_o};
    cap_locked[0] = {31'd0, if_a.locked_o};
    cap_gnt[1]    = {24'd0, if_b.gnt_o};
    cap_sel[1]    = {29'd0, if_b.sel_idx_o};
    cap_ptr[1]    = {29'd0, if_b.rr_ptr_o};
    cap_valid[1]  = {31'd0, if_b.valid_o};
    cap_locked[1] = {31'd0, if_b.locked_o};
  endtask

  task automatic compare_all();
    int          sel;
    bit          valid;
    int unsigned gnt;
    sample();
    for (int d = 0; d < 2; d++) begin
      model_out(d, sel, valid, gnt);
      check(d == 0 ? "a_valid"  : "b_valid",  cap_valid[d],  {31'd0, valid});
      check(d == 0 ? "a_gnt"    : "b_gnt",    cap_gnt[d],    gnt);
      check(d == 0 ? "a_sel"    : "b_sel",    cap_sel[d],    sel);
      check(d == 0 ? "a_ptr"    : "b_ptr",    cap_ptr[d],    m_ptr[d]);
      check(d == 0 ? "a_locked" : "b_locked", cap_locked[d], {31'd0, m_frozen[d]});
      check(d == 0 ? "a_onehot" : "b_onehot", {31'd0, $onehot0(cap_gnt[d])}, 1);
    end
  endtask

  // Compare at the falling edge, advance the model at the rising edge,
  // return just after the rising edge so the caller can drive new inputs.
  task automatic cycle();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_frozen[d] = 1'b0;
        m_ptr[d]    = 0;
        m_hold[d]   = 0;
      end else begin
        model_step(d);
      end
    end
    #1;
  endtask

  task automatic idle(input int d);
    req_v[d]   = 8'd0;
    last_v[d]  = 8'd0;
    ready_v[d] = 1'b0;
  endtask

  // ---------------- soak bookkeeping ----------------
  int beats_left[8];
  int wait_cnt  [8];
  int max_wait;
  int owner;
  int n_interleave;

  initial begin
    int g;
    rst_n = 1'b0;
    idle(0);
    idle(1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // reset state with no requests
    cycle();
    check("rst_a_ptr", cap_ptr[0], 0);
    check("rst_a_sel", cap_sel[0], 0);
    check("rst_a_valid", cap_valid[0], 0);
    check("rst_b_locked", cap_locked[1], 0);
    check("rst_b_gnt", cap_gnt[1], 0);

    // pointer wrap on A
    req_v[0] = 8'h1f; last_v[0] = 8'h00; ready_v[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("wrap_gnt", cap_gnt[0], 32'd1 << (k % 5));
      check("wrap_ptr", cap_ptr[0], k % 5);
    end

    // move pointer to 3, then priority skip
    req_v[0] = 8'b00100;
    cycle();
    check("skip_pre_gnt", cap_gnt[0], 32'b00100);
    req_v[0] = 8'b00101;
    cycle();
    check("skip_ptr3", cap_ptr[0], 3);
    check("skip_sel0", cap_sel[0], 0);
    cycle();
    check("skip_ptr1", cap_ptr[0], 1);
    check("skip_sel2", cap_sel[0], 2);

    // hold with ready low, another request appears meanwhile
    req_v[0] = 8'b00110; ready_v[0] = 1'b0;
    cycle();
    check("hold_c1_sel", cap_sel[0], 1);
    check("hold_c1_locked", cap_locked[0], 0);
    req_v[0] = 8'b01110;
    cycle();
    check("hold_c2_sel", cap_sel[0], 1);
    check("hold_c2_locked", cap_locked[0], 1);
    cycle();
    check("hold_c3_sel", cap_sel[0], 1);
    ready_v[0] = 1'b1;
    cycle();
    check("hold_release_gnt", cap_gnt[0], 32'b00010);
    idle(0);
    cycle();
    check("hold_after_locked", cap_locked[0], 0);

    // burst lock on B: move pointer to 2 first
    req_v[1] = 8'b0000_0010; last_v[1] = 8'b0000_0010; ready_v[1] = 1'b1;
    cycle();
    check("burst_pre_gnt", cap_gnt[1], 32'b0000_0010);
    for (int b = 0; b < 5; b++) begin
      // b==2 is the gap; b==4 is the last beat
      req_v[1]  = (b == 2) ? 8'b0000_0001 : 8'b0000_0101;
      last_v[1] = (b == 4) ? 8'b0000_0101 : 8'b0000_0001;
      cycle();
      check("burst_gnt", cap_gnt[1], (b == 2) ? 32'd0 : 32'b0000_0100);
      check("burst_locked", cap_locked[1], (b == 0) ? 0 : 1);
    end
    req_v[1] = 8'b0000_0001; last_v[1] = 8'b0000_0001;
    cycle();
    check("burst_next_gnt", cap_gnt[1], 32'b0000_0001);
    check("burst_ptr3", cap_ptr[1], 3);

    // reset during beat 2 of a lock on B
    req_v[1] = 8'b0000_0100; last_v[1] = 8'b0000_0000;
    cycle();
    cycle();
    check("rstlock_locked_pre", cap_locked[1], 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    sample();
    check("rstlock_locked", cap_locked[1], 0);
    check("rstlock_ptr", cap_ptr[1], 0);
    cycle();
    rst_n = 1'b1;
    req_v[1] = 8'b0000_0101;
    cycle();
    check("rstlock_free_sel", cap_sel[1], 0);
    check("rstlock_free_valid", cap_valid[1], 1);

    // randomized soak: A fully random, B AXI-like persistent bursts
    idle(1);
    cycle();
    for (int i = 0; i < 8; i++) begin
      beats_left[i] = 0;
      wait_cnt[i]   = 0;
    end
    max_wait     = 0;
    owner        = -1;
    n_interleave = 0;
    for (int c = 0; c < 3000; c++) begin
      req_v[0]   = 8'($urandom_range(0, 31));
      last_v[0]  = 8'($urandom_range(0, 31));
      ready_v[0] = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) begin
        if (beats_left[i] == 0 && $urandom_range(0, 3) == 0)
          beats_left[i] = $urandom_range(1, 4);
        req_v[1][i]  = (beats_left[i] > 0);
        last_v[1][i] = (beats_left[i] == 1);
      end
      ready_v[1] = ($urandom_range(0, 3) != 0);
      cycle();
      if (cap_gnt[1] != 0) begin
        g = 0;
        for (int i = 7; i >= 0; i--) if (cap_gnt[1][i]) g = i;
        if (owner >= 0 && g != owner) n_interleave++;
        if (last_v[1][g]) begin
          owner = -1;
          for (int j = 0; j < 8; j++) begin
            if (j != g && req_v[1][j]) begin
              wait_cnt[j]++;
              if (wait_cnt[j] > max_wait) max_wait = wait_cnt[j];
            end
          end
          wait_cnt[g] = 0;
        end else begin
          owner = g;
        end
        if (beats_left[g] > 0) beats_left[g]--;
      end
    end
    check("soak_no_interleave", n_interleave, 0);
    check("soak_max_wait_le7", (max_wait <= 7) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_rr_lock_arbiter.md
# axi_rr_lock_arbiter

Parametrised N-way round-robin arbiter with an integrated priority pointer, valid-hold and burst lock, for the AXI node arbitration trees (AR, AW, W, B and R channels). It selects one of `N_REQ` requesters per cycle and presents a valid/ready handshake downstream. After each completed transfer the priority pointer advances past the winner, wrapping at any `N_REQ`, not only powers of two. A transfer not accepted in its first cycle is held on the same winner until accepted. In lock mode the grant stays on one requester until a beat flagged `last` completes, which keeps W bursts contiguous.

## Interface
- `N_REQ`, 8: number of requesters, ≥ 2, need not be a power of two.
- `IDX_W`, `$clog2(N_REQ)`: width of the index and pointer outputs.
- `LOCK_ON_LAST`, 1: 1 holds the grant until a beat with `last` is accepted; 0 re-arbitrates after every beat.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_i`  in  N_REQ  per-requester valid.
- `last_i`  in  N_REQ  per-requester last-beat flag, sampled only for the selected requester.
- `ready_i`  in  1  downstream ready.
- `valid_o`  out  1  downstream valid.
- `gnt_o`  out  N_REQ  one-hot ready returned to the requesters.
- `sel_idx_o`  out  IDX_W  index of the selected requester, used as the mux select.
- `rr_ptr_o`  out  IDX_W  current highest-priority index.
- `locked_o`  out  1  high while in HOLD or LOCK.

## Operation
- States:
  - ARB: free arbitration.
  - HOLD: offered but not accepted; winner frozen.
  - LOCK: mid-burst; winner frozen.
- Registers:
  - `state`
  - `rr_ptr` (IDX_W)
  - `hold_idx` (IDX_W)
- ARB selection: the first index i with `req_i[i]=1`, scanning `rr_ptr`, `rr_ptr+1`, … , `N_REQ-1`, 0, … , `rr_ptr-1`.
- ARB outputs: `sel_idx_o` = that index. With no request, `sel_idx_o` = `rr_ptr`. `valid_o` = |`req_i`.
- HOLD/LOCK outputs: `sel_idx_o` = `hold_idx` and `valid_o` = `req_i[hold_idx]`. All other requests are ignored.
- `gnt_o[i]` = `valid_o` & `ready_i` & (i == `sel_idx_o`). At most one bit is set.
- A handshake is `valid_o` & `ready_i`. Let `done` = handshake & (`last_i[sel_idx_o]` | !`LOCK_ON_LAST`).
- ARB transitions:
  - `valid_o` & !`ready_i` → HOLD, `hold_idx` ← `sel_idx_o`.
  - handshake & !`done` → LOCK, `hold_idx` ← `sel_idx_o`.
  - `done` → stay in ARB and advance the pointer.
- HOLD/LOCK transitions:
  - `done` → ARB and advance the pointer.
  - handshake & !`done` → LOCK.
  - otherwise stay in the current state.
- Pointer advance: `rr_ptr` ← `sel_idx_o`+1, or 0 if `sel_idx_o` == `N_REQ-1`. The arithmetic is IDX_W-bit and must never reach a value ≥ `N_REQ`.
- `rr_ptr` changes only on `done`. A partial burst does not move it.
- If the locked requester drops `req_i`, the block stays in LOCK with `valid_o`=0. This is legal: W beats may have gaps.
- If the HOLD requester drops `req_i` (an AXI violation), the block stays in HOLD with `valid_o`=0 and does not re-arbitrate.

## Timing
- Reset values:
  - `state`=ARB, `rr_ptr`=0, `hold_idx`=0, `locked_o`=0.
  - `rr_ptr_o`=0, `sel_idx_o`=0.
  - `valid_o`=0 and `gnt_o`=0 while `req_i`=0.
- Reset asserted mid-burst or mid-hold returns the block to ARB with pointer 0 immediately. The lock is not retained.
- Zero-cycle latency: `req_i` → `valid_o`/`sel_idx_o` and `ready_i` → `gnt_o` are combinational.
- Throughput of one beat per cycle, including back-to-back single-beat grants to different requesters.
- State and pointer updates take effect on the cycle after the handshake.
- `locked_o` is registered: it rises in the cycle after the first unaccepted offer or non-last beat, and falls in the cycle after `done`.
- A request arriving in the same cycle as `done` competes in the next cycle against the updated pointer.

## Test plan
- Pointer wrap (`N_REQ`=5, `LOCK_ON_LAST`=0): all `req_i`=5'b11111, `ready_i`=1, `last_i`=0 → grants 0,1,2,3,4,0 on consecutive cycles; `rr_ptr_o` goes 0→1→2→3→4→0 and never reaches 5–7.
- Priority skip: `rr_ptr`=3, `req_i`=5'b00101 → `sel_idx_o`=0; after `done`, `rr_ptr_o`=1, and the next grant with the same requests is 2.
- Hold: `req_i`=5'b00110, `ready_i`=0 for 3 cycles with index 1 selected; raise `req_i[3]` meanwhile → `sel_idx_o` stays 1 and `locked_o`=1 from cycle 2; then `ready_i`=1 → `gnt_o`=5'b00010.
- Burst lock (`LOCK_ON_LAST`=1): requester 2 sends 4 beats with last on beat 4, one gap cycle with `req_i[2]`=0, requester 0 requesting throughout → `gnt_o` only ever 5'b00100 until beat 4; requester 0 is granted next cycle; `rr_ptr_o`=3 after the burst.
- Reset mid-lock: assert `rst_n`=0 during LOCK beat 2 → `locked_o`=0, `rr_ptr_o`=0, and `valid_o` follows free arbitration after release.
- Random N_REQ=8 soak: `gnt_o` is always one-hot or zero; each requester waits at most N_REQ−1 bursts; burst beats are never interleaved.
